// File: rtl/ternary_fabric_pkg.sv
// Shared definitions for the ternary fabric: frame sequencer state encoding,
// register bank offsets and the default word stride.
package ternary_fabric_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_WAIT,
    ST_PUSH,
    ST_FLUSH
  } seq_state_t;

  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_BASE  = 8'h08;
  localparam logic [7:0] REG_DEPTH = 8'h0C;

  localparam int unsigned SEQ_ADDR_STRIDE = 4;

endpackage

// File: rtl/ternary_frame_sequencer.sv
// Frame hydration sequencer: clears lane accumulators, then fetches cfg_depth
// packed-trit words from memory (one outstanding read) and hands each to the
// lane array over valid/ready.
// Optional: define SEQ_PERF_CNT_EN to add the perf_stall_cycles counter port.
module ternary_frame_sequencer
  import ternary_fabric_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_W     = 16,
  parameter int unsigned ADDR_STRIDE = SEQ_ADDR_STRIDE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [ADDR_W-1:0]  cfg_base_addr,
  input  logic [DEPTH_W-1:0] cfg_depth,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [DATA_W-1:0]  mem_rsp_data,
  output logic               lane_clear,
  output logic               lane_valid,
  input  logic               lane_ready,
  output logic [DATA_W-1:0]  lane_data,
  output logic               busy,
  output logic               done,
  output logic [DEPTH_W-1:0] words_done
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles
`endif
);

  seq_state_t         state, state_nx;
  logic [ADDR_W-1:0]  addr;
  logic [DEPTH_W-1:0] remaining;
  logic [DATA_W-1:0]  hold;
  logic               start_acc;
  logic               rsp_take;
  logic               lane_hs;

  assign mem_req_addr = addr;
  assign lane_data    = hold;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state and handshake outputs. Abort is folded in combinationally so an
  // aborted FETCH never presents a request and an aborted PUSH drops lane_valid
  // in the same cycle.
  always_comb begin
    state_nx      = state;
    mem_req_valid = 1'b0;
    lane_valid    = 1'b0;
    lane_clear    = 1'b0;
    start_acc     = 1'b0;
    rsp_take      = 1'b0;
    lane_hs       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cfg_start) begin
          start_acc = 1'b1;
          if (cfg_depth != '0) state_nx = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        lane_clear = 1'b1;
        state_nx   = cfg_abort ? ST_IDLE : ST_FETCH;
      end
      ST_FETCH: begin
        if (cfg_abort) begin
          state_nx = ST_IDLE;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response coinciding with abort is already consumed, so no flush.
        if (mem_rsp_valid) begin
          rsp_take = !cfg_abort;
          state_nx = cfg_abort ? ST_IDLE : ST_PUSH;
        end else if (cfg_abort) begin
          state_nx = ST_FLUSH;
        end
      end
      ST_PUSH: begin
        if (cfg_abort) begin
          state_nx = ST_IDLE;
        end else begin
          lane_valid = 1'b1;
          if (lane_ready) begin
            lane_hs  = 1'b1;
            state_nx = (remaining == DEPTH_W'(1)) ? ST_IDLE : ST_FETCH;
          end
        end
      end
      ST_FLUSH: begin
        if (mem_rsp_valid) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pass configuration, hold register, progress counters and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= '0;
      remaining  <= '0;
      hold       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
    end else if (start_acc) begin
      addr       <= cfg_base_addr;
      remaining  <= cfg_depth;
      words_done <= '0;
      done       <= (cfg_depth == '0);
      busy       <= (cfg_depth != '0);
    end else begin
      if (rsp_take) hold <= mem_rsp_data;
      if (lane_hs) begin
        words_done <= words_done + DEPTH_W'(1);
        addr       <= addr + ADDR_W'(ADDR_STRIDE);
        remaining  <= remaining - DEPTH_W'(1);
        if (remaining == DEPTH_W'(1)) done <= 1'b1;
      end
      if (state != ST_IDLE && state_nx == ST_IDLE) busy <= 1'b0;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic stall;

  // A cycle is a stall when the current state's handshake partner is not ready.
  always_comb begin
    stall = ((state == ST_FETCH) && !mem_req_ready) ||
            ((state == ST_WAIT)  && !mem_rsp_valid) ||
            ((state == ST_PUSH)  && !lane_ready);
  end

  // Saturating stall counter, restarted by each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      perf_stall_cycles <= '0;
    else if (start_acc)                perf_stall_cycles <= '0;
    else if (stall && perf_stall_cycles != '1) perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

endmodule
